// File: rtl/pc_sequencer.sv
// Fetch/program-flow controller: drives the ROM address, latches the instruction register and owns the return stack.
// Each transfer takes one cycle and costs one bubble; with en low, every register holds its value.
module pc_sequencer #(
  parameter int          ADDR_W      = 11,
  parameter int          STACK_DEPTH = 8,
  parameter logic [13:0] NOP_WORD    = 14'h0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [13:0]                  rom_data,
  input  logic                         skip_cond,
  output logic [ADDR_W-1:0]            rom_addr,
  output logic [13:0]                  ir,
  output logic                         ir_valid,
  output logic [$clog2(STACK_DEPTH):0] stack_depth,
  output logic                         stack_ovf,
  output logic                         stack_unf
);

  localparam int                   SP_W      = $clog2(STACK_DEPTH);
  localparam int                   DEPTH_W   = SP_W + 1;
  localparam logic [DEPTH_W-1:0]   DEPTH_MAX = DEPTH_W'(STACK_DEPTH);
  localparam logic [DEPTH_W-1:0]   DEPTH_MIN = '0;

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_seq;
  logic [ADDR_W-1:0]  pc_next;
  logic [ADDR_W-1:0]  pop_val;
  logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]    sp;
  logic [SP_W-1:0]    sp_inc;
  logic [SP_W-1:0]    sp_dec;
  logic [DEPTH_W-1:0] depth;

  logic op_goto;
  logic op_call;
  logic op_ret;
  logic op_skip;
  logic skip_taken;
  logic push;
  logic pop;
  logic flush;

  assign rom_addr    = pc;
  assign stack_depth = depth;

  // Only a real fetched word is decoded, so a bubble never starts a second transfer.
  always_comb begin
    op_goto    = ir_valid && (ir[13:11] == 3'b101);
    op_call    = ir_valid && (ir[13:11] == 3'b100);
    op_ret     = ir_valid && ((ir == 14'h0008) || (ir[13:10] == 4'b1101));
    op_skip    = ir_valid && ((ir[13:8] == 6'b001011) || (ir[13:8] == 6'b001111) ||
                              (ir[13:10] == 4'b0110)  || (ir[13:10] == 4'b0111));
    skip_taken = op_skip && skip_cond;
    push       = op_call;
    pop        = op_ret;
    flush      = op_goto || op_call || op_ret || skip_taken;
  end

  always_comb begin
    pc_seq  = pc + 1'b1;
    sp_inc  = sp + 1'b1;
    sp_dec  = sp - 1'b1;
    pop_val = stack_mem[sp_dec];
    pc_next = pc_seq;
    if (op_goto || op_call) begin
      pc_next = ir[ADDR_W-1:0];
    end else if (op_ret) begin
      pc_next = pop_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= '0;
      ir       <= NOP_WORD;
      ir_valid <= 1'b0;
    end else if (en) begin
      pc <= pc_next;
      if (flush) begin
        ir       <= NOP_WORD;
        ir_valid <= 1'b0;
      end else begin
        ir       <= rom_data;
        ir_valid <= 1'b1;
      end
    end
  end

  // Circular stack: overflow overwrites the oldest entry, underflow reads the wrapped slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= '0;
      depth     <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else if (en) begin
      if (push) begin
        sp <= sp_inc;
        if (depth == DEPTH_MAX) begin
          stack_ovf <= 1'b1;
        end else begin
          depth <= depth + 1'b1;
        end
      end else if (pop) begin
        sp <= sp_dec;
        if (depth == DEPTH_MIN) begin
          stack_unf <= 1'b1;
        end else begin
          depth <= depth - 1'b1;
        end
      end
    end
  end

  // The pushed return address is the current pc, i.e. the CALL's own address + 1.
  always_ff @(posedge clk) begin
    if (!rst && en && push) begin
      stack_mem[sp] <= pc;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a ROM model in the bench feeds rom_data from rom_addr.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        skip_cond = 1'b0;
  logic [13:0] rom_data;
  logic [10:0] rom_addr;
  logic [13:0] ir;
  logic        ir_valid;
  logic [3:0]  stack_depth;
  logic        stack_ovf;
  logic        stack_unf;

  logic [13:0] rom [2048];

  int total = 0;
  int bad = 0;

  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .rom_data   (rom_data),
    .skip_cond  (skip_cond),
    .rom_addr   (rom_addr),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .stack_depth(stack_depth),
    .stack_ovf  (stack_ovf),
    .stack_unf  (stack_unf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = 14'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b1;
    skip_cond = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_ir(input string tag, input logic [13:0] word, input int budget);
    int n;
    n = 0;
    while (!(ir_valid === 1'b1 && ir === word) && n < budget) begin
      step();
      n++;
    end
    check(tag, {31'b0, (ir_valid === 1'b1 && ir === word)}, 32'd1);
  endtask

  initial begin
    logic [10:0] ret_addr [9];
    logic [3:0]  ret_depth [9];

    // Reset and sequential fetch, plus pc wrap via GOTO 0x7FE.
    clear_rom();
    rom[0] = 14'h3006;
    rom[3] = 14'h2FFE;
    do_reset();
    check("rst_addr", 32'(rom_addr), 32'h000);
    check("rst_ir", 32'(ir), 32'h0000);
    check("rst_vld", 32'(ir_valid), 32'd0);
    check("rst_depth", 32'(stack_depth), 32'd0);
    check("rst_ovf", 32'(stack_ovf), 32'd0);
    check("rst_unf", 32'(stack_unf), 32'd0);
    step();
    check("seq1_addr", 32'(rom_addr), 32'h001);
    check("seq1_ir", 32'(ir), 32'h3006);
    check("seq1_vld", 32'(ir_valid), 32'd1);
    step();
    check("seq2_addr", 32'(rom_addr), 32'h002);
    step();
    check("seq3_addr", 32'(rom_addr), 32'h003);
    wait_ir("wait_goto7fe", 14'h2FFE, 10);
    step();
    check("goto7fe_addr", 32'(rom_addr), 32'h7FE);
    check("goto7fe_vld", 32'(ir_valid), 32'd0);
    step();
    check("wrap_7ff", 32'(rom_addr), 32'h7FF);
    step();
    check("wrap_000", 32'(rom_addr), 32'h000);

    // CALL at 7 to 0x014, RETURN at 0x1E back to 0x008.
    clear_rom();
    rom[7]     = 14'h2014;
    rom[8]     = 14'h1234;
    rom[11'h1E] = 14'h0008;
    do_reset();
    wait_ir("wait_call", 14'h2014, 20);
    check("pre_call_addr", 32'(rom_addr), 32'h008);
    step();
    check("call_addr", 32'(rom_addr), 32'h014);
    check("call_ir", 32'(ir), 32'h0000);
    check("call_vld", 32'(ir_valid), 32'd0);
    check("call_depth", 32'(stack_depth), 32'd1);
    wait_ir("wait_ret", 14'h0008, 30);
    step();
    check("ret_addr", 32'(rom_addr), 32'h008);
    check("ret_depth", 32'(stack_depth), 32'd0);
    check("ret_vld", 32'(ir_valid), 32'd0);
    step();
    check("ret_ir_next", 32'(ir), 32'h1234);
    check("ret_vld_next", 32'(ir_valid), 32'd1);
    check("ret_unf", 32'(stack_unf), 32'd0);

    // GOTO loop with DECFSZ skip not taken, then taken.
    clear_rom();
    rom[11'h18] = 14'h0BA2;
    rom[11'h19] = 14'h2818;
    rom[11'h1A] = 14'h0123;
    do_reset();
    wait_ir("wait_decfsz", 14'h0BA2, 40);
    check("decfsz_addr", 32'(rom_addr), 32'h019);
    step();
    check("noskip_ir", 32'(ir), 32'h2818);
    check("noskip_vld", 32'(ir_valid), 32'd1);
    step();
    check("goto_addr", 32'(rom_addr), 32'h018);
    check("goto_vld", 32'(ir_valid), 32'd0);
    step();
    check("loop_ir", 32'(ir), 32'h0BA2);
    skip_cond = 1'b1;
    step();
    check("skip_addr", 32'(rom_addr), 32'h01A);
    check("skip_vld", 32'(ir_valid), 32'd0);
    check("skip_ir", 32'(ir), 32'h0000);
    step();
    check("after_skip_ir", 32'(ir), 32'h0123);
    check("after_skip_vld", 32'(ir_valid), 32'd1);
    step();
    check("skipcond_ignored_vld", 32'(ir_valid), 32'd1);
    check("skipcond_ignored_addr", 32'(rom_addr), 32'h01C);
    skip_cond = 1'b0;

    // Nine nested CALLs, then nine RETURNs.
    clear_rom();
    for (int i = 0; i < 9; i++) rom[i * 16] = 14'(14'h2000 | ((i + 1) * 16));
    rom[11'h090] = 14'h0008;
    for (int i = 1; i <= 8; i++) rom[i * 16 + 1] = 14'h0008;
    ret_addr  = '{11'h081, 11'h071, 11'h061, 11'h051, 11'h041, 11'h031, 11'h021, 11'h011, 11'h081};
    ret_depth = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      wait_ir($sformatf("wait_ncall%0d", i), 14'(14'h2000 | ((i + 1) * 16)), 10);
      step();
      check($sformatf("ncall%0d_addr", i), 32'(rom_addr), 32'((i + 1) * 16));
      check($sformatf("ncall%0d_depth", i), 32'(stack_depth), (i < 8) ? 32'(i + 1) : 32'd8);
      check($sformatf("ncall%0d_ovf", i), 32'(stack_ovf), (i == 8) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 9; i++) begin
      wait_ir($sformatf("wait_nret%0d", i), 14'h0008, 10);
      step();
      check($sformatf("nret%0d_addr", i), 32'(rom_addr), 32'(ret_addr[i]));
      check($sformatf("nret%0d_depth", i), 32'(stack_depth), 32'(ret_depth[i]));
      check($sformatf("nret%0d_unf", i), 32'(stack_unf), (i == 8) ? 32'd1 : 32'd0);
    end
    check("nest_ovf_sticky", 32'(stack_ovf), 32'd1);

    // en low freezes a pending CALL; then reset during a pending CALL.
    clear_rom();
    rom[7] = 14'h2014;
    do_reset();
    check("flags_cleared", 32'({stack_ovf, stack_unf}), 32'd0);
    wait_ir("wait_call_en", 14'h2014, 20);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold%0d_addr", i), 32'(rom_addr), 32'h008);
      check($sformatf("hold%0d_depth", i), 32'(stack_depth), 32'd0);
      check($sformatf("hold%0d_ir", i), 32'(ir), 32'h2014);
    end
    en = 1'b1;
    step();
    check("resume_addr", 32'(rom_addr), 32'h014);
    check("resume_depth", 32'(stack_depth), 32'd1);

    do_reset();
    wait_ir("wait_call_rst", 14'h2014, 20);
    rst = 1'b1;
    step();
    check("rstcall_addr", 32'(rom_addr), 32'h000);
    check("rstcall_depth", 32'(stack_depth), 32'd0);
    check("rstcall_vld", 32'(ir_valid), 32'd0);
    rst = 1'b0;
    step();
    check("rstcall_after_addr", 32'(rom_addr), 32'h001);
    check("rstcall_after_depth", 32'(stack_depth), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
